deser16: RTL
============

DESER16 -- requirements
Module: deser16

Interface
REQ-001: clk  input  1  single clock; all state updates on its rising edge.
REQ-002: reset  input  1  asynchronous, active-high reset.
REQ-003: sin  input  1  serial data bit.
REQ-004: sin_valid  input  1  sin carries a bit this cycle.
REQ-005: sin_ready  output  1  block accepts a bit this cycle; a bit is accepted when sin_valid and sin_ready are both 1.
REQ-006: flush  input  1  discards the partially assembled word.
REQ-007: dout  output  16  assembled parallel word; stable while dout_valid=1.
REQ-008: dout_valid  output  1  dout holds an unconsumed word.
REQ-009: dout_ready  input  1  consumer takes dout when dout_valid and dout_ready are both 1.
REQ-010: bit_cnt  output  4  number of bits accepted into the current partial word (0..15).

Function
REQ-011: Each accepted bit SHALL shift into a 16-bit assembly register and increment bit_cnt by 1, modulo 16.
REQ-012: Bit order SHALL be LSB-first: the first accepted bit of a word lands in dout[0] and the 16th lands in dout[15].
REQ-013: On acceptance of the 16th bit (bit_cnt=15), the completed word SHALL load into the output holding register and bit_cnt SHALL wrap to 0.
REQ-014: dout_valid SHALL assert in the cycle after the 16th bit is accepted, giving a latency of 1 cycle.
REQ-015: dout_valid SHALL clear the cycle after a dout_valid and dout_ready handshake, unless a new word loads in that same cycle, in which case it SHALL stay 1 with the new dout.
REQ-016: sin_ready SHALL be 0 only when bit_cnt=15, dout_valid=1 and dout_ready=0; it SHALL be 1 in every other case, including back-to-back words with no bubble cycles.
REQ-017: flush SHALL clear bit_cnt and the assembly register in the next cycle and SHALL leave dout and dout_valid unchanged.
REQ-018: When flush and an accepted bit occur in the same cycle, flush SHALL win and the bit is discarded.
REQ-019: When flush and the 16th bit occur in the same cycle, no word SHALL load.
REQ-020: sin, sin_valid and dout_ready SHALL be ignored while reset is asserted.

Reset
REQ-021: Asserting reset SHALL immediately and asynchronously set dout=0x0000, dout_valid=0, bit_cnt=0 and clear the assembly register.
REQ-022: sin_ready SHALL read 1 during and after reset.
REQ-023: A reset that arrives mid-word SHALL discard the partial word; the first bit accepted after reset deasserts is bit 0 of a new word.

Configuration
REQ-024: With DESER_MSB_FIRST_EN defined, bit order SHALL be MSB-first: the first accepted bit lands in dout[15] and the 16th lands in dout[0].
REQ-025: Without DESER_MSB_FIRST_EN, the LSB-first order of REQ-012 SHALL apply.
REQ-026: All other behaviour, including timing, handshakes and flush, SHALL be identical in both builds.

Structure
REQ-027: A shared package deser16_pkg SHALL hold:
- WORD_W=16;
- CNT_W=4;
- the last-bit constant LAST_BIT=4'd15.
REQ-028: The bit counter SHALL be the sub-module deser16_bitcnt, with:
- clk, async reset, inc and clr inputs;
- a 4-bit count output;
- a last output that is 1 when count=15.
REQ-029: The assembly register, holding register and handshake logic SHALL reside in deser16.

Verification
REQ-030: Reset; send 16 bits of 0xA5C3 LSB-first with dout_ready=1 -> dout_valid=1 with dout=0xA5C3 exactly 1 cycle after the 16th accept, then dout_valid=0.
REQ-031: Stream 0xFFFF then 0x0001 back-to-back with dout_ready=1 -> sin_ready stays 1 throughout and two consecutive words appear 16 cycles apart.
REQ-032: Word 0x1234 is held with dout_ready=0 while 15 bits of the next word are sent -> sin_ready=0 at bit_cnt=15 and dout stays 0x1234. Then set dout_ready=1 -> the 16th bit is accepted in the same cycle as the drain and the next word loads with dout_valid kept at 1.
REQ-033: Send 5 bits, pulse flush together with a valid bit, then send 0x00F0 -> dout=0x00F0 and bit_cnt=0 the cycle after flush.
REQ-034: Assert reset asynchronously after 9 bits -> outputs clear without a clock edge, and the following word 0x8001 assembles correctly.
REQ-035: In the DESER_MSB_FIRST_EN build, send the bit sequence 1,0,0,...,0 (16 bits) -> dout=0x8000; the same sequence in the default build gives dout=0x0001.

Source files
------------

// File: rtl/deser16_pkg.sv
// deser16 shared constants and the bit-order helper.
// Build option: DESER_MSB_FIRST_EN selects MSB-first assembly.
package deser16_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = 4'd15;

    // Shift one serial bit into the assembly word in build-selected order.
    function automatic logic [WORD_W-1:0] shift_in(
        input logic [WORD_W-1:0] a,
        input logic              b
    );
`ifdef DESER_MSB_FIRST_EN
        return {a[WORD_W-2:0], b};
`else
        return {b, a[WORD_W-1:1]};
`endif
    endfunction

endpackage

// File: rtl/deser16_bitcnt.sv
// deser16 bit counter: counts accepted bits, wraps 15 -> 0.
// Build option DESER_MSB_FIRST_EN has no effect here.
module deser16_bitcnt
    import deser16_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] r_cnt;

    // Clear has priority over increment; natural wrap after LAST_BIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign count = r_cnt;
    assign last  = (r_cnt == LAST_BIT);

endmodule

// File: rtl/deser16.sv
// deser16: 16-bit serial-to-parallel deserializer with handshakes.
// Build option DESER_MSB_FIRST_EN: MSB-first instead of LSB-first.
module deser16
    import deser16_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              sin,
    input  logic              sin_valid,
    output logic              sin_ready,
    input  logic              flush,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [CNT_W-1:0]  bit_cnt
);

    logic [WORD_W-1:0] r_asm;
    logic [WORD_W-1:0] r_dout;
    logic              r_vld;

    logic              w_last;
    logic              w_ready;
    logic              w_acc;
    logic              w_inc;
    logic              w_load;
    logic              w_drain;
    logic [WORD_W-1:0] w_word;

    // Stall only the final bit, and only while the holder cannot drain.
    assign w_drain = r_vld & dout_ready;
    assign w_ready = ~(w_last & r_vld & ~dout_ready);
    assign w_acc   = sin_valid & w_ready;
    assign w_inc   = w_acc & ~flush;
    assign w_load  = w_inc & w_last;
    assign w_word  = shift_in(r_asm, sin);

    deser16_bitcnt u_bitcnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_inc),
        .clr   (flush),
        .count (bit_cnt),
        .last  (w_last)
    );

    // Assembly register: flush discards, accepted bits shift in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_asm <= '0;
        end else if (flush) begin
            r_asm <= '0;
        end else if (w_inc) begin
            r_asm <= w_word;
        end
    end

    // Holding register: a new word overrides a same-cycle drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout <= '0;
            r_vld  <= 1'b0;
        end else if (w_load) begin
            r_dout <= w_word;
            r_vld  <= 1'b1;
        end else if (w_drain) begin
            r_vld  <= 1'b0;
        end
    end

    assign sin_ready  = w_ready;
    assign dout       = r_dout;
    assign dout_valid = r_vld;

endmodule
